smart_ac_ctrl: RTL and testbench

//   Parametrised successor to the SmartAC mode controller. Holds a saturating fan mode (0..MAX_MODE)

---
 rtl/smart_ac_pkg.sv | 31 +++
 rtl/smart_ac_ctrl_seg7.sv | 36 +++
 rtl/smart_ac_ctrl.sv | 178 +++++++++++++++++
 tb/tb_smart_ac_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/smart_ac_pkg.sv
// Shared types and constants for the SmartAC fan-mode controller.
// Provides the 2-bit FSM state encoding and 7-segment glyphs.
// Segment order is {g,f,e,d,c,b,a}, active-high.
package smart_ac_pkg;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        MANUAL = 2'd1,
        AUTO   = 2'd2,
        SLEEP  = 2'd3
    } state_t;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/smart_ac_ctrl_seg7.sv
// Hex digit to 7-segment decoder, purely combinational (registered by the parent).
// Ports: value (4-bit digit), blank (force all segments off), seg ({g,f,e,d,c,b,a}).
// No state; output follows inputs in the same cycle.
module seg7_decoder
    import smart_ac_pkg::*;
(
    input  logic [3:0] value,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (value)
                4'h0:    seg = SEG_0;
                4'h1:    seg = SEG_1;
                4'h2:    seg = SEG_2;
                4'h3:    seg = SEG_3;
                4'h4:    seg = SEG_4;
                4'h5:    seg = SEG_5;
                4'h6:    seg = SEG_6;
                4'h7:    seg = SEG_7;
                4'h8:    seg = SEG_8;
                4'h9:    seg = SEG_9;
                4'hA:    seg = SEG_A;
                4'hB:    seg = SEG_B;
                4'hC:    seg = SEG_C;
                4'hD:    seg = SEG_D;
                4'hE:    seg = SEG_E;
                default: seg = SEG_F;
            endcase
        end
    end

endmodule

// File: rtl/smart_ac_ctrl.sv
// SmartAC fan-mode controller: saturating mode with button edges, thermostat AUTO,
// inactivity SLEEP, fan PWM and a registered 7-seg mode digit.
// Inputs: clk, rst (sync, active-high), SW, up_req, dn_req, auto_en, tick, temp_in, temp_set.
// Outputs: mode, state, fan_pwm, disp -- all registered; mode/state/disp change together.
module smart_ac_ctrl
    import smart_ac_pkg::*;
#(
    parameter int MAX_MODE    = 4,
    parameter int MODE_W      = 3,
    parameter int TEMP_W      = 8,
    parameter int HYST        = 2,
    parameter int SLEEP_TICKS = 16,
    parameter int PWM_W       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SW,
    input  logic              up_req,
    input  logic              dn_req,
    input  logic              auto_en,
    input  logic              tick,
    input  logic [TEMP_W-1:0] temp_in,
    input  logic [TEMP_W-1:0] temp_set,
    output logic [MODE_W-1:0] mode,
    output logic [1:0]        state,
    output logic              fan_pwm,
    output logic [6:0]        disp
);

    localparam int CNT_W = $clog2(SLEEP_TICKS + 1);
    localparam int CMP_W = PWM_W + MODE_W + 1;

    localparam logic [MODE_W-1:0] MODE_TOP  = MODE_W'(MAX_MODE);
    localparam logic [MODE_W-1:0] MODE_ONE  = MODE_W'(1);
    localparam logic [CNT_W-1:0]  SLEEP_LIM = CNT_W'(SLEEP_TICKS);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [TEMP_W:0]   HYST_X    = (TEMP_W + 1)'(HYST);

    state_t              state_q;
    state_t              state_d;
    logic [MODE_W-1:0]   mode_d;
    logic [CNT_W-1:0]    sleep_q;
    logic [CNT_W-1:0]    sleep_d;
    logic                up_q;
    logic                dn_q;
    logic                up_e;
    logic                dn_e;
    logic                temp_hot;
    logic                temp_cold;
    logic [PWM_W-1:0]    pwm_cnt;
    logic [CMP_W-1:0]    pwm_lhs;
    logic [CMP_W-1:0]    pwm_rhs;
    logic [3:0]          mode_d4;
    logic [6:0]          seg_next;

    assign up_e = up_req & ~up_q;
    assign dn_e = dn_req & ~dn_q;

    // One extra bit so setpoint/measurement plus hysteresis cannot wrap.
    assign temp_hot  = {1'b0, temp_in} > ({1'b0, temp_set} + HYST_X);
    assign temp_cold = ({1'b0, temp_in} + HYST_X) < {1'b0, temp_set};

    // Duty = mode/MAX_MODE: compare c*MAX_MODE against mode*2**PWM_W.
    assign pwm_lhs = CMP_W'(pwm_cnt) * CMP_W'(MAX_MODE);
    assign pwm_rhs = CMP_W'(mode) << PWM_W;

    assign state = state_q;

    always_comb begin
        state_d = state_q;
        mode_d  = mode;
        sleep_d = sleep_q;
        if (!SW) begin
            state_d = OFF;
            mode_d  = '0;
            sleep_d = '0;
        end else begin
            case (state_q)
                OFF: begin
                    state_d = auto_en ? AUTO : MANUAL;
                    mode_d  = MODE_ONE;
                    sleep_d = '0;
                end
                MANUAL: begin
                    if (auto_en) begin
                        state_d = AUTO;
                        sleep_d = '0;
                        if (mode == '0) begin
                            mode_d = MODE_ONE;
                        end
                    end else if (up_e || dn_e) begin
                        // Any edge is activity, even the cancelling up+down pair.
                        sleep_d = '0;
                        if (up_e && !dn_e && mode < MODE_TOP) begin
                            mode_d = mode + MODE_ONE;
                        end else if (dn_e && !up_e && mode != '0) begin
                            mode_d = mode - MODE_ONE;
                        end
                    end else if (tick && sleep_q < SLEEP_LIM) begin
                        if (sleep_q + CNT_ONE == SLEEP_LIM && mode > MODE_ONE) begin
                            state_d = SLEEP;
                            mode_d  = MODE_ONE;
                            sleep_d = '0;
                        end else begin
                            // At mode<=1 the count parks at the limit.
                            sleep_d = sleep_q + CNT_ONE;
                        end
                    end
                end
                AUTO: begin
                    if (!auto_en) begin
                        state_d = MANUAL;
                        sleep_d = '0;
                    end else if (tick) begin
                        if (temp_hot && mode < MODE_TOP) begin
                            mode_d = mode + MODE_ONE;
                        end else if (temp_cold && mode > MODE_ONE) begin
                            mode_d = mode - MODE_ONE;
                        end
                    end
                end
                SLEEP: begin
                    mode_d = MODE_ONE;
                    if (auto_en) begin
                        state_d = AUTO;
                    end else if (up_e || dn_e) begin
                        // Wake-up press is swallowed; no mode step.
                        state_d = MANUAL;
                        sleep_d = '0;
                    end
                end
                default: begin
                    state_d = OFF;
                    mode_d  = '0;
                    sleep_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= OFF;
            mode    <= '0;
            sleep_q <= '0;
        end else begin
            state_q <= state_d;
            mode    <= mode_d;
            sleep_q <= sleep_d;
        end
    end

    // Display decodes the next mode/state so it updates on the same edge as mode.
    assign mode_d4 = 4'(mode_d);

    seg7_decoder u_seg7 (
        .value (mode_d4),
        .blank (state_d == OFF),
        .seg   (seg_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            up_q    <= 1'b0;
            dn_q    <= 1'b0;
            pwm_cnt <= '0;
            fan_pwm <= 1'b0;
            disp    <= SEG_BLANK;
        end else begin
            up_q    <= up_req;
            dn_q    <= dn_req;
            pwm_cnt <= pwm_cnt + 1'b1;
            fan_pwm <= pwm_lhs < pwm_rhs;
            disp    <= seg_next;
        end
    end

endmodule

// File: tb/tb_smart_ac_ctrl.sv
// Directed bench for smart_ac_ctrl with default parameters.
// Table rows drive one cycle each and check mode/state/disp; hand sequences cover
// button hold, sleep timing, PWM duty, power-off and reset priority.
module tb_smart_ac_ctrl;

    logic       clk = 1'b0;
    logic       rst, SW, up_req, dn_req, auto_en, tick;
    logic [7:0] temp_in, temp_set;
    logic [2:0] mode;
    logic [1:0] state;
    logic       fan_pwm;
    logic [6:0] disp;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       sw, up, dn, au, tk;
        logic [7:0] tin, tset;
        logic [2:0] em;
        logic [1:0] es;
    } vec_t;

    vec_t vt [0:63];
    int   nv = 0;

    smart_ac_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .SW       (SW),
        .up_req   (up_req),
        .dn_req   (dn_req),
        .auto_en  (auto_en),
        .tick     (tick),
        .temp_in  (temp_in),
        .temp_set (temp_set),
        .mode     (mode),
        .state    (state),
        .fan_pwm  (fan_pwm),
        .disp     (disp)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] exp_seg(input logic [2:0] m, input logic [1:0] s);
        if (s == 2'd0) return 7'h00;
        case (m)
            3'd0:    return 7'h3F;
            3'd1:    return 7'h06;
            3'd2:    return 7'h5B;
            3'd3:    return 7'h4F;
            3'd4:    return 7'h66;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    task automatic check_ms(input string nm, input logic [2:0] em, input logic [1:0] es);
        check({nm, ".mode"},  32'(mode),  32'(em));
        check({nm, ".state"}, 32'(state), 32'(es));
        check({nm, ".disp"},  32'(disp),  32'(exp_seg(em, es)));
    endtask

    task automatic add(input logic sw, up, dn, au, tk, input logic [7:0] tin, tset,
                       input logic [2:0] em, input logic [1:0] es);
        vt[nv] = '{sw, up, dn, au, tk, tin, tset, em, es};
        nv++;
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            SW = vt[i].sw; up_req = vt[i].up; dn_req = vt[i].dn;
            auto_en = vt[i].au; tick = vt[i].tk;
            temp_in = vt[i].tin; temp_set = vt[i].tset;
            step();
            check_ms($sformatf("row%0d", i), vt[i].em, vt[i].es);
        end
        up_req = 1'b0; dn_req = 1'b0; tick = 1'b0;
    endtask

    task automatic pulse_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1; step();
            tick = 1'b0; step();
        end
    endtask

    task automatic count_pwm(input string nm, input int req);
        int hi;
        hi = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (fan_pwm === 1'b1) hi++;
        end
        check(nm, 32'(hi), 32'(req));
    endtask

    int m_lo, m_hi, a_lo, a_hi;

    initial begin
        // MANUAL rows: starting at mode 1
        m_lo = nv;
        add(1,1,0,0,0,0,0,2,1); add(1,0,0,0,0,0,0,2,1);
        add(1,1,0,0,0,0,0,3,1); add(1,0,0,0,0,0,0,3,1);
        add(1,1,0,0,0,0,0,4,1); add(1,0,0,0,0,0,0,4,1);
        add(1,1,0,0,0,0,0,4,1); add(1,0,0,0,0,0,0,4,1);
        add(1,0,1,0,0,0,0,3,1); add(1,0,0,0,0,0,0,3,1);
        add(1,1,1,0,0,0,0,3,1); add(1,0,0,0,0,0,0,3,1);
        add(1,0,1,0,0,0,0,2,1); add(1,0,0,0,0,0,0,2,1);
        add(1,0,1,0,0,0,0,1,1); add(1,0,0,0,0,0,0,1,1);
        add(1,0,1,0,0,0,0,0,1); add(1,0,0,0,0,0,0,0,1);
        add(1,0,1,0,0,0,0,0,1); add(1,0,0,0,0,0,0,0,1);
        add(1,1,0,0,0,0,0,1,1); add(1,0,0,0,0,0,0,1,1);
        add(1,1,0,0,0,0,0,2,1); add(1,0,0,0,0,0,0,2,1);
        m_hi = nv;
        // AUTO rows: starting at mode 1, setpoint 100, hysteresis 2
        a_lo = nv;
        add(1,0,0,1,1,103,100,2,2); add(1,0,0,1,0,103,100,2,2);
        add(1,0,0,1,1,103,100,3,2); add(1,0,0,1,0,103,100,3,2);
        add(1,0,0,1,1,103,100,4,2); add(1,0,0,1,0,103,100,4,2);
        add(1,0,0,1,1,103,100,4,2); add(1,0,0,1,1,102,100,4,2);
        add(1,0,0,1,0, 97,100,4,2); add(1,0,0,1,1, 97,100,3,2);
        add(1,0,0,1,1, 98,100,3,2); add(1,0,0,1,1, 97,100,2,2);
        add(1,1,0,1,0, 97,100,2,2); add(1,0,0,1,1, 97,100,1,2);
        add(1,0,0,1,1, 97,100,1,2); add(1,0,0,1,1,103,100,2,2);
        add(1,0,0,1,1,101,100,2,2); add(1,0,0,1,1,255,254,2,2);
        add(1,0,0,1,1,254,255,2,2); add(1,0,0,1,1,  0,  1,2,2);
        a_hi = nv;

        rst = 1'b1; SW = 1'b1; up_req = 1'b0; dn_req = 1'b0;
        auto_en = 1'b0; tick = 1'b0; temp_in = 8'd0; temp_set = 8'd0;

        for (int i = 0; i < 2; i++) begin
            step();
            check_ms("reset", 3'd0, 2'd0);
            check("reset.fan_pwm", 32'(fan_pwm), 32'd0);
        end
        rst = 1'b0;
        step();
        check_ms("release", 3'd1, 2'd1);

        run_rows(m_lo, m_hi);

        // Held button gives exactly one step.
        up_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("hold%0d.mode", i), 32'(mode), 32'd3);
        end
        up_req = 1'b0;
        step();

        // Sleep after 16 idle ticks at mode 3.
        pulse_ticks(15);
        check_ms("tick15", 3'd3, 2'd1);
        tick = 1'b1; step(); tick = 1'b0;
        check_ms("sleep", 3'd1, 2'd3);
        step();
        dn_req = 1'b1; step();
        check_ms("wake", 3'd1, 2'd1);
        dn_req = 1'b0; step();

        // At mode 1 the timer saturates without sleeping; a press restarts it.
        pulse_ticks(20);
        check_ms("sat_m1", 3'd1, 2'd1);
        up_req = 1'b1; step();
        check_ms("restart", 3'd2, 2'd1);
        up_req = 1'b0; step();
        pulse_ticks(15);
        check_ms("restart15", 3'd2, 2'd1);
        pulse_ticks(1);
        check_ms("sleep2", 3'd1, 2'd3);

        auto_en = 1'b1; step();
        check_ms("sleep_auto", 3'd1, 2'd2);

        run_rows(a_lo, a_hi);
        auto_en = 1'b1; temp_in = 8'd103; temp_set = 8'd100;

        count_pwm("pwm_m2", 8);
        tick = 1'b1; step(); step(); tick = 1'b0;
        check_ms("auto_m4", 3'd4, 2'd2);
        count_pwm("pwm_m4", 16);

        SW = 1'b0; step();
        check_ms("sw_off", 3'd0, 2'd0);
        step();
        count_pwm("pwm_off", 0);

        SW = 1'b1; step();
        check_ms("on_auto", 3'd1, 2'd2);
        auto_en = 1'b0; step();
        check_ms("to_manual", 3'd1, 2'd1);

        rst = 1'b1; up_req = 1'b1; step();
        check_ms("rst_prio", 3'd0, 2'd0);
        check("rst_prio.fan_pwm", 32'(fan_pwm), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
